// File: rtl/piano_pkg.sv
// Shared piano constants, note indices and the key-judge state encoding.
package piano_pkg;

  localparam int NOTE_W       = 4;
  localparam int DEF_NUM_KEYS = 7;

  localparam logic [NOTE_W-1:0] C = 4'd0;
  localparam logic [NOTE_W-1:0] D = 4'd1;
  localparam logic [NOTE_W-1:0] E = 4'd2;
  localparam logic [NOTE_W-1:0] F = 4'd3;
  localparam logic [NOTE_W-1:0] G = 4'd4;
  localparam logic [NOTE_W-1:0] A = 4'd5;
  localparam logic [NOTE_W-1:0] B = 4'd6;

  typedef enum logic [1:0] {
    RELEASE_WAIT,
    ARMED,
    COOLDOWN
  } judge_state_t;

endpackage

// File: rtl/key_debounce.sv
// Single-button 2-flop synchroniser followed by a stability-count debouncer.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Any sample that agrees with the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], btn_raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_press_judge.sv
// Debounces piano buttons and judges each new press against the expected note.
// Optional armed-wait timeout is enabled by defining KEY_JUDGE_TIMEOUT_EN.
module key_press_judge
  import piano_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int HOLDOFF_CYCLES  = 10_000_000,
  parameter int CNT_W           = 8,
  parameter int TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NOTE_W-1:0]   key,
  input  logic [NUM_KEYS-1:0] btn_raw,
  output logic                correct_key_press,
  output logic                wrong_key,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count,
  output logic [CNT_W-1:0]    streak,
  output logic                armed,
  output logic                timeout
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  logic [NUM_KEYS-1:0] db;
  logic [NUM_KEYS-1:0] db_d1;
  logic [NUM_KEYS-1:0] press_vec;
  logic                hit_ok;

  judge_state_t state, state_n;
  logic [HW-1:0]    cd_cnt, cd_n;
  logic [CNT_W-1:0] hit_n, miss_n, streak_n;
  logic             cor_n, wrong_n, to_n;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btn_raw[i]),
      .level  (db[i])
    );
  end

  assign press_vec = db & ~db_d1;
  assign hit_ok    = (32'(key) < NUM_KEYS) &&
                     (press_vec == (NUM_KEYS'(1) << key));
  assign armed     = (state == ARMED);

`ifdef KEY_JUDGE_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wait_cnt, wait_n;
`endif

  always_comb begin
    state_n  = state;
    cd_n     = cd_cnt;
    hit_n    = hit_count;
    miss_n   = miss_count;
    streak_n = streak;
    cor_n    = 1'b0;
    wrong_n  = 1'b0;
    to_n     = 1'b0;
`ifdef KEY_JUDGE_TIMEOUT_EN
    wait_n   = wait_cnt;
`endif
    unique case (state)
      RELEASE_WAIT: begin
        if (db == '0) begin
          state_n = ARMED;
`ifdef KEY_JUDGE_TIMEOUT_EN
          wait_n  = '0;
`endif
        end
      end
      ARMED: begin
        if (press_vec != '0) begin
`ifdef KEY_JUDGE_TIMEOUT_EN
          wait_n = '0;
`endif
          if (hit_ok) begin
            cor_n    = 1'b1;
            hit_n    = (hit_count == '1) ? hit_count : hit_count + 1'b1;
            streak_n = (streak == '1) ? streak : streak + 1'b1;
            cd_n     = '0;
            state_n  = COOLDOWN;
          end else begin
            wrong_n  = 1'b1;
            miss_n   = (miss_count == '1) ? miss_count : miss_count + 1'b1;
            streak_n = '0;
          end
        end
`ifdef KEY_JUDGE_TIMEOUT_EN
        else if (wait_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
          to_n     = 1'b1;
          miss_n   = (miss_count == '1) ? miss_count : miss_count + 1'b1;
          streak_n = '0;
          wait_n   = '0;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
`endif
      end
      COOLDOWN: begin
        if (cd_cnt == HW'(HOLDOFF_CYCLES - 1)) begin
          state_n = RELEASE_WAIT;
        end else begin
          cd_n = cd_cnt + 1'b1;
        end
      end
      default: state_n = RELEASE_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= RELEASE_WAIT;
      db_d1             <= '0;
      cd_cnt            <= '0;
      hit_count         <= '0;
      miss_count        <= '0;
      streak            <= '0;
      correct_key_press <= 1'b0;
      wrong_key         <= 1'b0;
    end else begin
      state             <= state_n;
      db_d1             <= db;
      cd_cnt            <= cd_n;
      hit_count         <= hit_n;
      miss_count        <= miss_n;
      streak            <= streak_n;
      correct_key_press <= cor_n;
      wrong_key         <= wrong_n;
    end
  end

`ifdef KEY_JUDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= wait_n;
      timeout  <= to_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_key_press_judge.sv
// Self-checking bench for key_press_judge with short debounce/holdoff settings.
module tb_key_press_judge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic [6:0] btn_raw;
  logic       correct_key_press, wrong_key, armed, timeout;
  logic [3:0] hit_count, miss_count, streak;

  int n_tests = 0;
  int n_fail  = 0;
  int m_hit = 0, m_miss = 0, m_streak = 0;

  key_press_judge #(
    .NUM_KEYS       (7),
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (8),
    .CNT_W          (4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .key              (key),
    .btn_raw          (btn_raw),
    .correct_key_press(correct_key_press),
    .wrong_key        (wrong_key),
    .hit_count        (hit_count),
    .miss_count       (miss_count),
    .streak           (streak),
    .armed            (armed),
    .timeout          (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_hit"}, int'(hit_count), m_hit);
    chk({tag, "_miss"}, int'(miss_count), m_miss);
    chk({tag, "_streak"}, int'(streak), m_streak);
  endtask

  // One press of `mask` held `hold` cycles from edge t; response expected at t+7.
  task automatic step(input logic [6:0] mask, input logic [3:0] k,
                      input int hold, input string tag);
    int cor_at = -1, wr_at = -1, cor_n = 0, wr_n = 0, both = 0, to_n = 0;
    int armed_mid = -1;
    bit ok;
    ok = (k < 4'd7) && (mask == (7'd1 << k));
    key = k;
    btn_raw = mask;
    for (int i = 0; i < hold + 20; i++) begin
      @(posedge clk);
      #1;
      if (correct_key_press) begin cor_n++; cor_at = i; end
      if (wrong_key) begin wr_n++; wr_at = i; end
      if (correct_key_press && wrong_key) both++;
      if (timeout) to_n++;
      if (i == 10) armed_mid = int'(armed);
      if (i == hold - 1) btn_raw = '0;
    end
    if (ok) begin
      m_hit = sat(m_hit + 1);
      m_streak = sat(m_streak + 1);
    end else begin
      m_miss = sat(m_miss + 1);
      m_streak = 0;
    end
    chk({tag, "_cor_at"}, cor_at, ok ? 7 : -1);
    chk({tag, "_wr_at"}, wr_at, ok ? -1 : 7);
    chk({tag, "_npulse"}, cor_n + wr_n, 1);
    chk({tag, "_both"}, both, 0);
    chk({tag, "_timeout"}, to_n, 0);
    chk({tag, "_armed_mid"}, armed_mid, ok ? 0 : 1);
    chk({tag, "_armed_end"}, int'(armed), 1);
    chk_counters(tag);
  endtask

  initial begin
    int pulses;
    int seen;
    rst_n = 1'b0;
    key = '0;
    btn_raw = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", int'({correct_key_press, wrong_key, hit_count, miss_count,
                          streak, armed, timeout}), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_armed", int'(armed), 1);

    // Reset in the middle of a pending press leaves no residue
    key = 4'd4;
    btn_raw = 7'b001_0000;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", int'({correct_key_press, wrong_key, hit_count, miss_count,
                             streak, armed, timeout}), 0);
    btn_raw = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (correct_key_press || wrong_key || timeout) pulses++;
    end
    chk("midrst_pulses", pulses, 0);
    chk("midrst_armed", int'(armed), 1);
    chk_counters("midrst");

    // Directed cases
    step(7'b001_0000, 4'd4, 20, "hit4");
    step(7'b000_1000, 4'd2, 12, "wrong3");
    step(7'b000_0100, 4'd2, 12, "hit2");

    // Bouncing button never settles long enough
    key = 4'd0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      btn_raw = (i % 4 < 2) ? 7'b000_0001 : 7'b000_0000;
      @(posedge clk);
      #1;
      if (correct_key_press || wrong_key) pulses++;
    end
    btn_raw = '0;
    repeat (6) @(posedge clk);
    #1;
    chk("glitch_pulses", pulses, 0);
    chk_counters("glitch");

    step(7'b010_0010, 4'd1, 12, "chord");
    step(7'b000_0001, 4'd9, 12, "key9");

    // Randomized presses
    for (int n = 0; n < 20; n++) begin
      logic [6:0] m;
      logic [3:0] k;
      int hold;
      if ($urandom_range(0, 9) < 7)
        m = 7'd1 << $urandom_range(0, 6);
      else
        m = 7'($urandom_range(1, 127));
      if ($urandom_range(0, 1) == 1 && m != 0)
        k = 4'($clog2(int'(m) + 1) - 1);
      else
        k = 4'($urandom_range(0, 15));
      hold = $urandom_range(8, 14);
      step(m, k, hold, $sformatf("rnd%0d", n));
    end

    // Saturation
    for (int n = 0; n < 16; n++) begin
      logic [3:0] k;
      k = 4'($urandom_range(0, 6));
      step(7'd1 << k, k, 8, $sformatf("sat%0d", n));
    end
    chk("sat_hit15", int'(hit_count), 15);
    chk("sat_streak15", int'(streak), 15);

`ifdef KEY_JUDGE_TIMEOUT_EN
    btn_raw = '0;
    seen = 0;
    for (int i = 0; i < 80 && seen == 0; i++) begin
      @(posedge clk);
      #1;
      if (timeout) seen = 1;
    end
    chk("to_seen", seen, 1);
    m_miss = sat(m_miss + 1);
    m_streak = 0;
    chk_counters("to");
    chk("to_armed", int'(armed), 1);
    @(posedge clk);
    #1;
    chk("to_width", int'(timeout), 0);
`else
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (timeout) seen++;
    end
    chk("no_timeout", seen, 0);
    chk_counters("idle");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_press_judge.md
Name: key_press_judge

Overview:
- Player-side end of the learning-mode handshake. The song sequencer presents an expected note on key and waits for correct_key_press.
- This block debounces the raw piano buttons and detects new presses. It compares each press against the expected note.
- It returns a 1-cycle correct_key_press pulse to the sequencer on a match, and a wrong_key pulse otherwise.
- It keeps saturating hit/miss/streak counters for the score display.

Parameters:
NUM_KEYS, 7, number of piano buttons; button i means note index i
DEBOUNCE_CYCLES, 2_000_000, consecutive stable cycles before a debounced level changes (20 ms at 100 MHz)
HOLDOFF_CYCLES, 10_000_000, cooldown after a hit before re-arming
CNT_W, 8, width of the score counters
TIMEOUT_CYCLES, 500_000_000, armed-wait limit; used only with KEY_JUDGE_TIMEOUT_EN

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key  in  4  expected note index from the song sequencer
btn_raw  in  NUM_KEYS  raw, unsynchronised button levels, active-high
correct_key_press  out  1  1-cycle pulse: matching press accepted
wrong_key  out  1  1-cycle pulse: non-matching press
hit_count  out  CNT_W  saturating count of correct presses
miss_count  out  CNT_W  saturating count of wrong presses and timeouts
streak  out  CNT_W  saturating count of consecutive hits; cleared on any miss
armed  out  1  high while in ARMED
timeout  out  1  1-cycle pulse; tied 0 without KEY_JUDGE_TIMEOUT_EN

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0.
  - Debouncers and synchronisers cleared.
  - state = RELEASE_WAIT.
  - Reset mid-operation aborts any cooldown or pending pulse with no residual pulse.
- Input path:
  - btn_raw passes through a 2-flop synchroniser, then a per-button debouncer.
  - A debounced level flips only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any glitch restarts the count.
  - press_vec = debounced & ~debounced_d1, one cycle wide per button.
- Latency: with a raw press stable from cycle t, the debounced rise occurs at t+2+DEBOUNCE_CYCLES and the response pulse one cycle later.
- State RELEASE_WAIT: wait until all debounced buttons are low, then go to ARMED. No pulses in this state.
- State ARMED (armed=1), on a cycle where press_vec != 0:
  - Exactly one bit set, that bit == key, and key < NUM_KEYS:
    - Pulse correct_key_press.
    - hit_count++ and streak++, both saturating at 2^CNT_W-1.
    - Go to COOLDOWN.
  - Otherwise (chord, wrong key, or key >= NUM_KEYS):
    - Pulse wrong_key.
    - miss_count++ (saturating); streak = 0.
    - Stay in ARMED.
  - key is sampled on the same cycle as press_vec. A key change without a press has no effect.
- State COOLDOWN:
  - Counter runs 0..HOLDOFF_CYCLES-1, then goes to RELEASE_WAIT.
  - Presses during COOLDOWN are ignored and not counted.
- Guarantees:
  - correct_key_press and wrong_key are never high on the same cycle.
  - Each pulse is exactly one cycle.
- Counter saturation: counters hold at max and never wrap.

Optional Feature:
- KEY_JUDGE_TIMEOUT_EN defined:
  - A wait counter runs while in ARMED and clears on entry to ARMED and on any press.
  - Reaching TIMEOUT_CYCLES pulses timeout, increments miss_count, clears streak, restarts the wait counter, and stays in ARMED.
  - A press on the same cycle as expiry wins; no timeout is raised.
- KEY_JUDGE_TIMEOUT_EN undefined: no wait counter; timeout is constant 0.

Decomposition:
- Shared package piano_pkg holds:
  - NOTE_W=4 and default NUM_KEYS=7.
  - Note index constants C=0 through B=6.
  - The judge state enum {RELEASE_WAIT, ARMED, COOLDOWN}.
- One sub-module, key_debounce: a single-bit synchroniser plus debouncer, parameterised by DEBOUNCE_CYCLES and instantiated NUM_KEYS times via generate.

Test Plan (DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8, TIMEOUT_CYCLES=50, CNT_W=4):
- Reset with btn_raw=0 -> all outputs 0. armed=1 at the first clock after rst_n rises.
- key=4; btn_raw[4] high for 20 cycles from t -> correct_key_press exactly at t+7, hit_count=1, streak=1, armed=0. Re-armed only after release, debounce, and 8 cooldown cycles.
- key=2; press btn 3 -> wrong_key 1-cycle pulse, miss_count=1, streak=0, still armed. Then press btn 2 -> correct_key_press.
- key=0; btn_raw[0] toggles every 2 cycles for 20 cycles -> no pulse, counters unchanged.
- Buttons 1 and 5 pressed together with key=1 -> wrong_key. key=9 with btn 0 pressed -> wrong_key.
- 16 correct presses -> hit_count=15 and streak=15, saturated. With KEY_JUDGE_TIMEOUT_EN: idle 50 cycles in ARMED -> timeout pulse, miss_count++, streak=0.
